// File: rtl/riscv_fetch_pkg.sv
// ----------------------------------------------------------------------------
// riscv_fetch_pkg
// Shared definitions for the instruction fetch slice: the JAL opcode and the
// J-type immediate decoder used by the optional static JAL predictor.
// No ports (package).
// ----------------------------------------------------------------------------
package riscv_fetch_pkg;

    localparam logic [6:0] OPCODE_JAL = 7'b1101111;

    // Sign-extended J-immediate: imm[20|10:1|11|19:12] packed in instr[31:12].
    function automatic logic [31:0] j_imm(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic is_jal(input logic [31:0] instr);
        return instr[6:0] == OPCODE_JAL;
    endfunction

endpackage

// File: rtl/riscv_fetch_queue.sv
// ----------------------------------------------------------------------------
// riscv_fetch_queue
// Synchronous FIFO holding fetched entries between instruction memory and
// decode. Flush empties the queue and overrides push/pop in the same cycle.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   flush           discard all entries
//   push, push_data write one entry (ignored when full without a pop)
//   pop             remove head (ignored when empty)
//   head_data       current head entry
//   count           occupancy, 0..DEPTH
//   empty           count == 0
// ----------------------------------------------------------------------------
module riscv_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty     = (count == '0);
        do_pop    = pop && !empty && !flush;
        // A pop in the same cycle frees the slot a full queue would need.
        do_push   = push && !flush && ((count != (AW+1)'(DEPTH)) || do_pop);
        head_data = storage[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/riscv_fetch_unit.sv
// ----------------------------------------------------------------------------
// riscv_fetch_unit
// Sequential instruction fetch with a small decoupling queue. One request may
// be in flight; its response (one cycle later) is pushed with its address.
// Execute-stage redirects flush everything and restart at redirect_pc.
// Optional macro FETCH_JAL_PREDICT_EN enables static always-taken JAL
// prediction on the pushed word; without it fetch is strictly sequential and
// out_pred_taken is 0.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   imem_req, imem_addr           request to instruction memory (always taken)
//   imem_rdata                    response, valid one cycle after a request
//   redirect_valid, redirect_pc   control-flow change from execute
//   out_valid, out_ready          head handshake toward decode
//   out_instr, out_pc             head instruction and its address
//   out_pred_taken                head was predicted taken (JAL)
// ----------------------------------------------------------------------------
module riscv_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_pred_taken
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

`ifdef FETCH_JAL_PREDICT_EN
    localparam int ENTRY_W = 65;
`else
    localparam int ENTRY_W = 64;
`endif

    logic [31:0]        fetch_pc;
    logic               inflight;
    logic [31:0]        inflight_pc;
    logic [CW-1:0]      q_count;
    logic               q_empty;
    logic [ENTRY_W-1:0] q_head;
    logic [ENTRY_W-1:0] q_push_data;
    logic               rsp_push;
    logic               predict;
    logic [31:0]        predict_pc;
    logic [CW:0]        occupancy;

    always_comb begin
        // Reserve a slot for the outstanding response so the queue never overflows.
        occupancy = {1'b0, q_count} + (CW+1)'(inflight);
        imem_req  = rst_n && !redirect_valid && (occupancy < (CW+1)'(QUEUE_DEPTH));
        imem_addr = fetch_pc;
        // A redirect in the response cycle drops the returning word.
        rsp_push  = rst_n && inflight && !redirect_valid;
`ifdef FETCH_JAL_PREDICT_EN
        predict     = rsp_push && is_jal(imem_rdata);
        predict_pc  = inflight_pc + j_imm(imem_rdata);
        q_push_data = {predict, inflight_pc, imem_rdata};
`else
        predict     = 1'b0;
        predict_pc  = fetch_pc;
        q_push_data = {inflight_pc, imem_rdata};
`endif
        out_valid = rst_n && !q_empty;
        out_instr = q_head[31:0];
        out_pc    = q_head[63:32];
`ifdef FETCH_JAL_PREDICT_EN
        out_pred_taken = out_valid && q_head[64];
`else
        out_pred_taken = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            if (redirect_valid)
                fetch_pc <= redirect_pc;
            else if (predict)
                fetch_pc <= predict_pc;
            else if (imem_req)
                fetch_pc <= fetch_pc + 32'd4;
            // The sequential request issued alongside a predicted JAL is
            // wrong-path; not tracking it drops its response next cycle.
            inflight    <= imem_req && !predict;
            inflight_pc <= fetch_pc;
        end
    end

    riscv_fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (rsp_push),
        .push_data (q_push_data),
        .pop       (out_valid && out_ready),
        .head_data (q_head),
        .count     (q_count),
        .empty     (q_empty)
    );

endmodule

// File: tb/tb_riscv_fetch_unit.sv
module tb_riscv_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'hDEADBEEF;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_pred_taken;

    int checks = 0;
    int errors = 0;
    logic jal_mode = 1'b0;

    always #5 clk = ~clk;

    riscv_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pred_taken (out_pred_taken)
    );

    // Memory returns the address as data, except a JAL at 0x20 in jal_mode.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (jal_mode && a == 32'h20) return 32'h0100006F;
        return a;
    endfunction

    always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEADBEEF;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Ends in cycle 0: first cycle with rst_n=1, outputs settled.
    task automatic do_reset;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        out_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b expected 0", out_pred_taken); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL reset_first_req: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_c1_valid: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL reset_c2_head: got valid=%b pc=%h expected valid=1 pc=00000000", out_valid, out_pc); end
    endtask

    task automatic test_stream;
        out_ready = 1'b1;
        do_reset();
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4*i) || out_instr !== 32'(4*i)) begin
                errors++; $display("FAIL stream_%0d: got valid=%b pc=%h instr=%h expected valid=1 pc=instr=%h", i, out_valid, out_pc, out_instr, 32'(4*i));
            end
            tick();
        end
    endtask

    task automatic test_stall;
        int reqs;
        reqs = 0;
        out_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (imem_req === 1'b1) reqs++;
            if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
                    errors++; $display("FAIL stall_head_c%0d: got valid=%b pc=%h instr=%h expected valid=1 pc=instr=00000000", c, out_valid, out_pc, out_instr);
                end
            end
            if (c >= 4) begin
                checks++;
                if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_c%0d: got %b expected 0", c, imem_req); end
            end
            tick();
        end
        checks++; if (reqs != 4) begin errors++; $display("FAIL stall_reqs: got %0d expected 4", reqs); end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4*i)) begin
                errors++; $display("FAIL drain_%0d: got valid=%b pc=%h expected valid=1 pc=%h", i, out_valid, out_pc, 32'(4*i));
            end
            tick();
        end
    endtask

    task automatic test_redirect;
        out_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 4; c++) tick();
        // Cycle N: three entries queued, response for pc 0xC arriving.
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        out_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req_n: got %b expected 0", imem_req); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_req_n1: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_n1: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_n2: got %b expected 0", out_valid); end
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4*i) || out_instr !== 32'h100 + 32'(4*i)) begin
                errors++; $display("FAIL redir_n%0d: got valid=%b pc=%h instr=%h expected valid=1 pc=instr=%h", i+3, out_valid, out_pc, out_instr, 32'h100 + 32'(4*i));
            end
            tick();
        end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'hFFFFFFF8; exp_pc[1] = 32'hFFFFFFFC; exp_pc[2] = 32'h0; exp_pc[3] = 32'h4;
        out_ready = 1'b1;
        do_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFFFFF8;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc[i]) begin
                errors++; $display("FAIL wrap_%0d: got valid=%b pc=%h expected valid=1 pc=%h", i, out_valid, out_pc, exp_pc[i]);
            end
            tick();
        end
    endtask

    task automatic test_jal;
        logic [31:0] exp_pc [4];
        logic        exp_pred [4];
        logic [31:0] got_pc [4];
        logic        got_pred [4];
        logic [31:0] got_instr [4];
        int n;
        exp_pc[0] = 32'h18; exp_pc[1] = 32'h1C; exp_pc[2] = 32'h20;
`ifdef FETCH_JAL_PREDICT_EN
        exp_pc[3] = 32'h30;
        exp_pred[0] = 1'b0; exp_pred[1] = 1'b0; exp_pred[2] = 1'b1; exp_pred[3] = 1'b0;
`else
        exp_pc[3] = 32'h24;
        exp_pred[0] = 1'b0; exp_pred[1] = 1'b0; exp_pred[2] = 1'b0; exp_pred[3] = 1'b0;
`endif
        n = 0;
        jal_mode = 1'b1;
        out_ready = 1'b1;
        do_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h18;
        tick();
        redirect_valid = 1'b0;
        for (int c = 0; c < 14 && n < 4; c++) begin
            if (out_valid === 1'b1) begin
                got_pc[n] = out_pc; got_pred[n] = out_pred_taken; got_instr[n] = out_instr;
                n++;
            end
            tick();
        end
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL jal_count: got %0d entries expected 4", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_pc[i] !== exp_pc[i] || got_pred[i] !== exp_pred[i]) begin
                    errors++; $display("FAIL jal_entry_%0d: got pc=%h pred=%b expected pc=%h pred=%b", i, got_pc[i], got_pred[i], exp_pc[i], exp_pred[i]);
                end
            end
            checks++;
            if (got_instr[2] !== 32'h0100006F) begin errors++; $display("FAIL jal_word: got %h expected 0100006f", got_instr[2]); end
        end
        jal_mode = 1'b0;
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 4; c++) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_in_reset: got req=%b valid=%b expected 0 0", imem_req, out_valid); end
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid_after: got %b expected 0", out_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_req: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_c1_valid: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0) begin errors++; $display("FAIL midrst_first: got valid=%b pc=%h instr=%h expected valid=1 pc=instr=00000000", out_valid, out_pc, out_instr); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin errors++; $display("FAIL midrst_second: got valid=%b pc=%h expected valid=1 pc=00000004", out_valid, out_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_jal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/riscv_fetch_unit.md
RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, fetch-queue entries; power of two, >= 2.
REQ-002 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port imem_req  output  1  read request to instruction memory; always accepted.
REQ-006 SHALL have port imem_addr  output  32  request address, valid while imem_req=1.
REQ-007 SHALL have port imem_rdata  input  32  read data, valid exactly one cycle after an accepted request.
REQ-008 SHALL have port redirect_valid  input  1  execute-stage control-flow change (jump, taken branch).
REQ-009 SHALL have port redirect_pc  input  32  new fetch address, sampled when redirect_valid=1.
REQ-010 SHALL have port out_valid  output  1  queue head valid.
REQ-011 SHALL have port out_ready  input  1  decode accepts head; out_ready=0 is a decode stall.
REQ-012 SHALL have port out_instr  output  32  head instruction word.
REQ-013 SHALL have port out_pc  output  32  head instruction address.
REQ-014 SHALL have port out_pred_taken  output  1  head was predicted taken by the fetch unit.

Function
REQ-015 SHALL assert imem_req when rst_n=1, redirect_valid=0 and (queue occupancy + in-flight count) < QUEUE_DEPTH; the queue SHALL never overflow.
REQ-016 SHALL drive imem_addr from fetch_pc and advance fetch_pc by 4 per accepted request, wrapping 32'hFFFFFFFC -> 32'h0.
REQ-017 SHALL allow at most one in-flight request and SHALL record its address alongside it.
REQ-018 SHALL push {imem_rdata, recorded address} into the queue in the response cycle; the entry is visible on out_* the following cycle.
REQ-019 SHALL pop the head when out_valid && out_ready; push and pop in the same cycle SHALL both take effect and leave occupancy unchanged.
REQ-020 SHALL sustain one instruction per cycle when out_ready is held at 1.
REQ-021 On redirect_valid=1, SHALL flush the queue, discard any in-flight response (epoch tag), set fetch_pc <= redirect_pc and drive imem_req=0 that cycle.
REQ-022 SHALL treat a head presented in a redirect cycle as discarded, even if out_ready=1.
REQ-023 SHALL issue the first request at redirect_pc in cycle N+1 after a redirect in cycle N, and assert out_valid in cycle N+3.
REQ-024 SHALL hold out_instr, out_pc and out_pred_taken stable while out_valid=1 and out_ready=0.
REQ-025 SHALL hold out_valid=0 when the queue is empty; out_instr/out_pc are don't-care then.

Reset
REQ-026 While rst_n=0: fetch_pc=RESET_PC, queue empty, in-flight cleared, imem_req=0, out_valid=0, out_pred_taken=0.
REQ-027 SHALL issue the first request at RESET_PC in the first cycle with rst_n=1, and assert out_valid two cycles later.
REQ-028 Reset mid-operation SHALL discard queued and in-flight data; no pre-reset response SHALL be pushed after release.

Configuration
REQ-029 Macro FETCH_JAL_PREDICT_EN defined: when a pushed word has opcode 7'b1101111 (JAL), its entry SHALL carry pred_taken=1, fetch_pc SHALL become entry pc + sign-extended J-immediate, and any in-flight sequential request SHALL be discarded.
REQ-030 Under FETCH_JAL_PREDICT_EN, external redirect_valid in the same cycle SHALL take priority over the prediction.
REQ-031 Macro not defined: no prediction logic, out_pred_taken tied to 0, fetch strictly sequential except on redirect_valid.

Structure
REQ-032 The JAL opcode constant and the J-immediate extraction function SHALL live in the shared defs package; no new typedefs.
REQ-033 The queue SHALL be a sub-module riscv_fetch_queue (synchronous FIFO, parameter DEPTH, push/pop/flush, count output).

Verification
REQ-034 Reset release, RESET_PC=0, memory returns addr as data, out_ready=1 -> out_pc 0,4,8,... one per cycle from cycle 2; out_instr equals out_pc.
REQ-035 out_ready=0 for 10 cycles, QUEUE_DEPTH=4 -> exactly 4 entries queued, imem_req=0 once full, head pc=0 held stable; release drains 0,4,8,12 in order with no gaps.
REQ-036 Redirect to 32'h100 while queue holds 3 entries and one in flight -> no stale pc emitted; out_valid first at N+3 with out_pc=32'h100.
REQ-037 fetch_pc=32'hFFFFFFF8, out_ready=1 -> out_pc sequence FFFFFFF8, FFFFFFFC, 00000000.
REQ-038 FETCH_JAL_PREDICT_EN, word 32'h0100006F (jal x0,+16) at pc 32'h20 -> that entry out_pred_taken=1; next emitted out_pc=32'h30; pc 32'h24 never emitted.
REQ-039 rst_n=0 for one cycle with queue full and a request in flight -> out_valid=0 next cycle; after release, first out_pc=RESET_PC.
